// File: rtl/io_bank_pkg.sv
// Shared types for the I/O port bank: access FSM states and status-word bit positions.
package io_bank_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int STAT_FULL = 0;
  localparam int STAT_OVR  = 1;

endpackage

// File: rtl/io_in_buffer.sv
// One-entry input holding register with ready/valid intake and a sticky overrun flag.
module io_in_buffer #(
  parameter int WORD_W = 10
) (
  input  logic              clock,
  input  logic              n_reset,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              pop,
  input  logic              clr_ovr,
  output logic [WORD_W-1:0] rd_data,
  output logic              full,
  output logic              overrun
);

  logic [WORD_W-1:0] data;

  assign in_ready = !full;
  assign rd_data  = full ? data : '0;

  // A push only happens when empty and a pop only when full, so they never collide.
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      data    <= '0;
      full    <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (in_valid && !full) begin
        data <= in_data;
        full <= 1'b1;
      end else if (pop) begin
        full <= 1'b0;
      end
      // A fresh overrun on the same edge as a status read must not be lost.
      if (in_valid && full)
        overrun <= 1'b1;
      else if (clr_ovr)
        overrun <= 1'b0;
    end
  end

endmodule

// File: rtl/io_port_bank.sv
// Memory-mapped bank of output ports, one input buffer and a status word on a shared tristate bus.
module io_port_bank
  import io_bank_pkg::*;
#(
  parameter int WORD_W    = 10,
  parameter int OP_W      = 3,
  parameter int N_OUT     = 4,
  parameter int BASE_ADDR = 120
) (
  input  logic                          clock,
  input  logic                          n_reset,
  inout  wire  [WORD_W-1:0]             sysbus,
  input  logic                          CS,
  input  logic                          load_MAR,
  input  logic                          load_MDR,
  input  logic                          R_NW,
  output logic [N_OUT-1:0][WORD_W-1:0]  port_out,
  output logic [N_OUT-1:0]              port_stb,
  input  logic [WORD_W-1:0]             in_data,
  input  logic                          in_valid,
  output logic                          in_ready
);

  localparam int ADDR_W    = WORD_W - OP_W;
  localparam int IN_ADDR   = BASE_ADDR + N_OUT;
  localparam int STAT_ADDR = IN_ADDR + 1;

  if (STAT_ADDR >= (1 << ADDR_W)) begin : g_addr_range_bad
    $error("io_port_bank: STAT_ADDR does not fit in ADDR_W bits");
  end

  state_t            state, state_n;
  logic [ADDR_W-1:0] mar;
  logic [WORD_W-1:0] mdr;
  logic [N_OUT-1:0]  port_hit;
  logic              in_hit, stat_hit, rd_hit;
  logic [WORD_W-1:0] rd_val;
  logic              acc, wr_en, rd_en;
  logic [WORD_W-1:0] buf_data;
  logic              buf_full, buf_ovr;

  for (genvar i = 0; i < N_OUT; i++) begin : g_hit
    assign port_hit[i] = (mar == ADDR_W'(BASE_ADDR + i));
  end
  assign in_hit   = (mar == ADDR_W'(IN_ADDR));
  assign stat_hit = (mar == ADDR_W'(STAT_ADDR));

  always_comb begin
    rd_val = '0;
    rd_hit = 1'b0;
    for (int i = 0; i < N_OUT; i++) begin
      if (port_hit[i]) begin
        rd_val = port_out[i];
        rd_hit = 1'b1;
      end
    end
    if (in_hit) begin
      rd_val = buf_data;
      rd_hit = 1'b1;
    end
    if (stat_hit) begin
      rd_val            = '0;
      rd_val[STAT_FULL] = buf_full;
      rd_val[STAT_OVR]  = buf_ovr;
      rd_hit            = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) state <= IDLE;
    else          state <= state_n;
  end

  // An access fires once per CS assertion; register loads pre-empt it on the same edge.
  always_comb begin
    state_n = state;
    acc     = 1'b0;
    if (load_MAR) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE: if (CS && !load_MDR) begin
          acc     = 1'b1;
          state_n = (R_NW && rd_hit) ? DRIVE : DONE;
        end
        DRIVE, DONE: if (!CS) state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  assign wr_en = acc && !R_NW;
  assign rd_en = acc && R_NW;

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      mar      <= '0;
      mdr      <= '0;
      port_out <= '0;
      port_stb <= '0;
    end else begin
      if (load_MAR)
        mar <= sysbus[ADDR_W-1:0];
      else if (load_MDR)
        mdr <= sysbus;
      else if (rd_en && rd_hit)
        mdr <= rd_val;
      port_stb <= wr_en ? port_hit : '0;
      for (int i = 0; i < N_OUT; i++)
        if (wr_en && port_hit[i]) port_out[i] <= mdr;
    end
  end

  // Reset term makes the release immediate even before the state register settles.
  assign sysbus = (n_reset && state == DRIVE && CS && R_NW) ? mdr : {WORD_W{1'bz}};

  io_in_buffer #(.WORD_W(WORD_W)) u_in_buf (
    .clock    (clock),
    .n_reset  (n_reset),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .pop      (rd_en && in_hit),
    .clr_ovr  (rd_en && stat_hit),
    .rd_data  (buf_data),
    .full     (buf_full),
    .overrun  (buf_ovr)
  );

endmodule

// File: tb/tb_io_port_bank.sv
// Directed bench for io_port_bank; a bus pullup makes a released bus read as all ones.
module tb_io_port_bank;

  localparam int WORD_W = 10;
  localparam int N_OUT  = 4;
  localparam logic [WORD_W-1:0] ZV = '1;

  logic                         clock = 1'b0;
  logic                         n_reset = 1'b0;
  logic                         CS = 1'b0, load_MAR = 1'b0, load_MDR = 1'b0, R_NW = 1'b0;
  logic [WORD_W-1:0]            in_data = '0;
  logic                         in_valid = 1'b0;
  logic                         in_ready;
  logic [N_OUT-1:0][WORD_W-1:0] port_out;
  logic [N_OUT-1:0]             port_stb;
  logic [WORD_W-1:0]            tb_bus = '0;
  logic                         tb_drv = 1'b0;
  wire  [WORD_W-1:0]            sysbus;

  int n_chk = 0;
  int n_err = 0;

  assign sysbus = tb_drv ? tb_bus : {WORD_W{1'bz}};
  pullup (sysbus);

  always #5 clock = ~clock;

  io_port_bank #(.WORD_W(WORD_W), .OP_W(3), .N_OUT(N_OUT), .BASE_ADDR(120)) dut (
    .clock    (clock),
    .n_reset  (n_reset),
    .sysbus   (sysbus),
    .CS       (CS),
    .load_MAR (load_MAR),
    .load_MDR (load_MDR),
    .R_NW     (R_NW),
    .port_out (port_out),
    .port_stb (port_stb),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic set_mar(input logic [WORD_W-1:0] a);
    @(negedge clock);
    tb_bus = a; tb_drv = 1'b1; load_MAR = 1'b1;
    @(negedge clock);
    load_MAR = 1'b0; tb_drv = 1'b0;
  endtask

  task automatic set_mdr(input logic [WORD_W-1:0] v);
    @(negedge clock);
    tb_bus = v; tb_drv = 1'b1; load_MDR = 1'b1;
    @(negedge clock);
    load_MDR = 1'b0; tb_drv = 1'b0;
  endtask

  task automatic do_write(input logic [WORD_W-1:0] a, input logic [WORD_W-1:0] v);
    set_mar(a);
    set_mdr(v);
    R_NW = 1'b0; CS = 1'b1;
    @(negedge clock);
    CS = 1'b0;
    @(negedge clock);
  endtask

  task automatic do_read(input string tag, input logic [WORD_W-1:0] a, input logic [WORD_W-1:0] exp);
    set_mar(a);
    R_NW = 1'b1; CS = 1'b1;
    @(negedge clock);
    chk(tag, sysbus, exp);
    CS = 1'b0;
    #1 chk({tag, "_rel"}, sysbus, ZV);
    @(negedge clock);
  endtask

  initial begin
    int cnt;

    // Reset state
    #3;
    chk("rst_port_out", port_out, '0);
    chk("rst_port_stb", port_stb, '0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_bus_z", sysbus, ZV);
    @(negedge clock);
    n_reset = 1'b1;

    // Single write held for three cycles strobes once
    set_mar(10'd122);
    set_mdr(10'h155);
    R_NW = 1'b0; CS = 1'b1;
    cnt = 0;
    @(negedge clock);
    chk("stb_vec", port_stb, 4'b0100);
    cnt += int'(port_stb[2]);
    repeat (2) begin
      @(negedge clock);
      cnt += int'(port_stb[2]);
    end
    CS = 1'b0;
    @(negedge clock);
    cnt += int'(port_stb[2]);
    chk("stb_count", cnt, 1);
    chk("port2_val", port_out[2], 10'h155);

    // Write then read back port 0
    do_write(10'd120, 10'h0AA);
    chk("port0_val", port_out[0], 10'h0AA);
    do_read("rd_port0", 10'd120, 10'h0AA);
    do_read("rd_port2", 10'd122, 10'h155);

    // Input buffer fill and drain
    @(negedge clock);
    in_data = 10'h3C1; in_valid = 1'b1;
    @(negedge clock);
    in_valid = 1'b0;
    chk("in_ready_full", in_ready, 1'b0);
    do_read("rd_in", 10'd124, 10'h3C1);
    chk("in_ready_empty", in_ready, 1'b1);
    do_read("rd_in_empty", 10'd124, 10'h000);

    // Overrun: second word while full
    @(negedge clock);
    in_data = 10'h111; in_valid = 1'b1;
    @(negedge clock);
    in_data = 10'h222;
    @(negedge clock);
    in_valid = 1'b0;
    do_read("stat_ovr", 10'd125, 10'h003);
    do_read("stat_clr", 10'd125, 10'h001);
    do_read("rd_in_kept", 10'd124, 10'h111);
    do_read("stat_empty", 10'd125, 10'h000);

    // Read miss leaves the bus released
    set_mar(10'd5);
    R_NW = 1'b1; CS = 1'b1;
    @(negedge clock);
    chk("miss_no_drive", sysbus, ZV);
    CS = 1'b0;
    @(negedge clock);

    // Write to input address has no side effects
    do_write(10'd124, 10'h2AB);
    chk("wr_in_ports", port_out, {10'h000, 10'h155, 10'h000, 10'h0AA});
    chk("wr_in_ready", in_ready, 1'b1);

    // Reset asserted mid-drive releases bus at once
    set_mar(10'd120);
    R_NW = 1'b1; CS = 1'b1;
    @(negedge clock);
    chk("drive_pre_rst", sysbus, 10'h0AA);
    #2 n_reset = 1'b0;
    #1 chk("rst_drive_z", sysbus, ZV);
    chk("rst_ports_clr", port_out, '0);
    chk("rst_ready", in_ready, 1'b1);
    CS = 1'b0;
    @(negedge clock);
    n_reset = 1'b1;

    // Unmapped write: no port change, no strobe
    do_write(10'd121, 10'h123);
    chk("port1_val", port_out[1], 10'h123);
    set_mar(10'd5);
    set_mdr(10'h2F0);
    R_NW = 1'b0; CS = 1'b1;
    cnt = 0;
    repeat (3) begin
      @(negedge clock);
      cnt += int'(port_stb != '0);
    end
    CS = 1'b0;
    @(negedge clock);
    chk("unmapped_stb", cnt, 0);
    chk("unmapped_ports", port_out, {10'h000, 10'h000, 10'h123, 10'h000});

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
